tdm_demux4: RTL and testbench
=============================

# tdm_demux4

Receive-side demultiplexer for a 4-slot time-division-multiplexed bus. The transmit side steers four data words onto one shared bus, one word per beat, and marks slot 0 with `sync`. This block tracks the slot position with a counter and a small FSM, and collects the four words into shadow registers. When a frame is complete, it commits all four words to its outputs in one edge. It sits directly after the bus and feeds the frame consumers.

## Interface
- `WIDTH`, default 4: width of each data word and each output word.
- `clk` input, 1 bit: single clock, rising edge.
- `reset` input, 1 bit: synchronous, active-high reset.
- `valid` input, 1 bit: the beat on `d` is meaningful this cycle.
- `sync` input, 1 bit: qualified by `valid`; marks the beat as slot 0 of a frame.
- `d` input, WIDTH bits: slot data.
- `p` input, 1 bit: even-parity bit for `d`. Used only when the parity macro is defined.
- `y0`, `y1`, `y2`, `y3` output, WIDTH bits each: last committed frame, slots 0 to 3.
- `frame_valid` output, 1 bit: one-cycle pulse; the `y*` outputs have just been updated.
- `sync_err` output, 1 bit: one-cycle pulse; framing violation detected.
- `par_err` output, 1 bit: one-cycle pulse; frame dropped because of a parity error.

## Operation
- State: FSM {HUNT, RECV, EXPECT}; 2-bit `slot` counter; shadow registers `s0` to `s3`; sticky `bad` flag.
- Cycles with `valid`=0 are stalls. State, counter, shadows and outputs all hold; the pulse outputs go low.
- HUNT:
  - `valid`&`sync`: write `d` to `s0`, set `slot`=1, clear `bad`, go to RECV.
  - `valid`&!`sync`: ignore silently.
- RECV:
  - `valid`&!`sync`: write `d` to `s[slot]` and increment `slot`.
  - When `slot`==3: commit `s0`, `s1`, `s2` and `d` to `y0` to `y3`; pulse `frame_valid`; go to EXPECT with `slot`=0.
- RECV, premature `sync` (`valid`&`sync`):
  - Pulse `sync_err` and discard the partial frame.
  - Restart with `d` in `s0`, `slot`=1, `bad` cleared, stay in RECV.
- EXPECT:
  - `valid`&`sync`: handle as in HUNT (back-to-back frames are allowed without gaps).
  - `valid`&!`sync`: pulse `sync_err` and go to HUNT.
- Outputs `y*` change only on a commit. A discarded frame never modifies them.
- The counter is 2 bits. Wrap from 3 to 0 happens only on a commit, never by free-running.

## Timing
- Reset values: `y0` to `y3`=0; `frame_valid`, `sync_err` and `par_err`=0; FSM=HUNT; `slot`=0; `bad`=0; shadows=0.
- Reset asserted mid-frame discards the partial frame. The first beat after reset release is evaluated in HUNT.
- Latency: the slot-3 beat is sampled on edge N. On that same edge N, `y*` take the new values and `frame_valid` goes high; it is low again after edge N+1 unless another commit occurs.
- Minimum frame: 4 consecutive valid beats. Sustained throughput is one frame per 4 valid cycles.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- Macro: `TDM_DEMUX_PARITY_CHECK_EN`.
- With the macro defined:
  - Every valid beat is checked by XOR-reducing `{d,p}`. A result of 1 sets `bad`.
  - At the slot-3 commit point with `bad`=1 (or with the slot-3 beat itself bad), `y*` are not updated and `frame_valid` stays 0. `par_err` pulses instead; the FSM still goes to EXPECT.
  - `sync_err` has priority over `par_err`: a premature `sync` clears `bad`.
- Without the macro: `p` is ignored, `par_err` is tied to 0, and no parity logic is synthesized.

## Test plan
- Basic frame: after reset, beats (sync,3),(5),(A),(F) with `valid`=1 each cycle → one cycle after the last beat, `y0..y3`=3,5,A,F and `frame_valid`=1 for exactly one cycle.
- Stalls: the same frame with `valid`=0 for 2 cycles between every beat → identical result, with `frame_valid` one cycle after the F beat.
- Premature sync: beats (sync,1),(2),(sync,7),(8),(9),(4) → `sync_err` pulses one cycle after the second sync, then `y*`=7,8,9,4. The first frame never appears on `y*`.
- Missing sync: a complete frame, then (6) without sync → `sync_err` pulse; FSM in HUNT; beats without sync are ignored until the next sync; `y*` are unchanged.
- Reset mid-frame: (sync,1),(2), `reset` for one cycle, then (3),(4) without sync → no `frame_valid`; `y*` stay 0.
- Parity (macro defined): frame 3,5,A,F with the `p` of the slot-2 beat inverted → `par_err`=1 for one cycle; `frame_valid`=0; `y*` keep the previous frame. A following clean frame commits normally.

Source files
------------

// File: rtl/tdm_demux4.sv
// Receive-side demultiplexer for a 4-slot TDM bus: collects one frame into shadows and commits it in one edge.
// Optional per-beat even-parity checking is enabled by defining TDM_DEMUX_PARITY_CHECK_EN.
module tdm_demux4 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid,
  input  logic             sync,
  input  logic [WIDTH-1:0] d,
  input  logic             p,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2,
  output logic [WIDTH-1:0] y3,
  output logic             frame_valid,
  output logic             sync_err,
  output logic             par_err
);

  localparam logic [1:0] ST_HUNT   = 2'd0;
  localparam logic [1:0] ST_RECV   = 2'd1;
  localparam logic [1:0] ST_EXPECT = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [1:0]       slot_q, slot_d;
  // Slot 3 never needs a shadow: it is committed straight from d.
  logic [WIDTH-1:0] s0_q, s0_d, s1_q, s1_d, s2_q, s2_d;
  logic [WIDTH-1:0] y0_q, y0_d, y1_q, y1_d, y2_q, y2_d, y3_q, y3_d;
  logic             frame_valid_q, frame_valid_d;
  logic             sync_err_q, sync_err_d;
  logic             par_err_q, par_err_d;
  logic             start_frame, end_frame;
  logic             frame_bad;

`ifdef TDM_DEMUX_PARITY_CHECK_EN
  logic bad_q, bad_d;
  logic beat_bad;

  assign beat_bad  = ^{d, p};
  assign frame_bad = bad_q | beat_bad;
`else
  logic unused_p;

  assign unused_p  = p;
  assign frame_bad = 1'b0;
`endif

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d       = state_q;
    slot_d        = slot_q;
    s0_d          = s0_q;
    s1_d          = s1_q;
    s2_d          = s2_q;
    y0_d          = y0_q;
    y1_d          = y1_q;
    y2_d          = y2_q;
    y3_d          = y3_q;
    frame_valid_d = 1'b0;
    sync_err_d    = 1'b0;
    par_err_d     = 1'b0;
    start_frame   = 1'b0;
    end_frame     = 1'b0;
`ifdef TDM_DEMUX_PARITY_CHECK_EN
    bad_d         = bad_q;
`endif

    if (valid) begin
      case (state_q)
        ST_HUNT: begin
          if (sync) start_frame = 1'b1;
        end
        ST_RECV: begin
          if (sync) begin
            sync_err_d  = 1'b1;
            start_frame = 1'b1;
          end else if (slot_q == 2'd3) begin
            end_frame = 1'b1;
          end else begin
            case (slot_q)
              2'd1:    s1_d = d;
              2'd2:    s2_d = d;
              default: ;
            endcase
            slot_d = slot_q + 2'd1;
`ifdef TDM_DEMUX_PARITY_CHECK_EN
            bad_d  = bad_q | beat_bad;
`endif
          end
        end
        ST_EXPECT: begin
          if (sync) begin
            start_frame = 1'b1;
          end else begin
            sync_err_d = 1'b1;
            state_d    = ST_HUNT;
          end
        end
        default: state_d = ST_HUNT;
      endcase
    end

    if (start_frame) begin
      s0_d    = d;
      slot_d  = 2'd1;
      state_d = ST_RECV;
`ifdef TDM_DEMUX_PARITY_CHECK_EN
      bad_d   = beat_bad;
`endif
    end

    // A bad frame still ends normally; it just never reaches the outputs.
    if (end_frame) begin
      state_d = ST_EXPECT;
      slot_d  = 2'd0;
`ifdef TDM_DEMUX_PARITY_CHECK_EN
      bad_d   = 1'b0;
`endif
      if (frame_bad) begin
        par_err_d = 1'b1;
      end else begin
        y0_d          = s0_q;
        y1_d          = s1_q;
        y2_d          = s2_q;
        y3_d          = d;
        frame_valid_d = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_HUNT;
      slot_q        <= 2'd0;
      s0_q          <= '0;
      s1_q          <= '0;
      s2_q          <= '0;
      y0_q          <= '0;
      y1_q          <= '0;
      y2_q          <= '0;
      y3_q          <= '0;
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
      par_err_q     <= 1'b0;
`ifdef TDM_DEMUX_PARITY_CHECK_EN
      bad_q         <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      slot_q        <= slot_d;
      s0_q          <= s0_d;
      s1_q          <= s1_d;
      s2_q          <= s2_d;
      y0_q          <= y0_d;
      y1_q          <= y1_d;
      y2_q          <= y2_d;
      y3_q          <= y3_d;
      frame_valid_q <= frame_valid_d;
      sync_err_q    <= sync_err_d;
      par_err_q     <= par_err_d;
`ifdef TDM_DEMUX_PARITY_CHECK_EN
      bad_q         <= bad_d;
`endif
    end
  end

  assign y0          = y0_q;
  assign y1          = y1_q;
  assign y2          = y2_q;
  assign y3          = y3_q;
  assign frame_valid = frame_valid_q;
  assign sync_err    = sync_err_q;
  assign par_err     = par_err_q;

endmodule

// File: tb/tb_tdm_demux4.sv
// Self-checking bench for tdm_demux4: frame-level queue model compared every cycle, plus literal checkpoints.
module tb_tdm_demux4;

  localparam int WIDTH = 4;

`ifdef TDM_DEMUX_PARITY_CHECK_EN
  localparam bit          PAR_EN = 1'b1;
  localparam int          FV_A = 8,  PE_A = 1, FV_B = 9,  FV_C = 9,  PE_C = 2;
  localparam logic [15:0] Y_A  = 16'h1234, Y_C = 16'h6789;
`else
  localparam bit          PAR_EN = 1'b0;
  localparam int          FV_A = 9,  PE_A = 0, FV_B = 10, FV_C = 11, PE_C = 0;
  localparam logic [15:0] Y_A  = 16'h35AF, Y_C = 16'hABCD;
`endif

  logic             clk = 1'b0;
  logic             reset, valid, sync, p;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] y0, y1, y2, y3;
  logic             frame_valid, sync_err, par_err;

  tdm_demux4 #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .valid      (valid),
    .sync       (sync),
    .d          (d),
    .p          (p),
    .y0         (y0),
    .y1         (y1),
    .y2         (y2),
    .y3         (y3),
    .frame_valid(frame_valid),
    .sync_err   (sync_err),
    .par_err    (par_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int fv_seen = 0, se_seen = 0, pe_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the current partial frame is a queue of words; hunting means waiting for a sync;
  // an empty queue while not hunting means a frame just completed and a sync must follow.
  logic [WIDTH-1:0] fb[$];
  bit               fb_bad, hunting, model_ready = 1'b0;
  logic [15:0]      exp_y;
  bit               exp_fv, exp_se, exp_pe;

  always @(posedge clk) begin
    bit bb;
    exp_fv = 1'b0;
    exp_se = 1'b0;
    exp_pe = 1'b0;
    if (reset) begin
      fb.delete();
      fb_bad      = 1'b0;
      hunting     = 1'b1;
      exp_y       = '0;
      model_ready = 1'b1;
    end else if (valid) begin
      bb = PAR_EN && (^{d, p});
      if (sync) begin
        if (!hunting && fb.size() > 0) exp_se = 1'b1;
        fb.delete();
        fb.push_back(d);
        fb_bad  = bb;
        hunting = 1'b0;
      end else if (!hunting) begin
        if (fb.size() == 0) begin
          exp_se  = 1'b1;
          hunting = 1'b1;
        end else begin
          fb.push_back(d);
          fb_bad = fb_bad | bb;
          if (fb.size() == 4) begin
            if (fb_bad) exp_pe = 1'b1;
            else begin
              exp_y  = {fb[0], fb[1], fb[2], fb[3]};
              exp_fv = 1'b1;
            end
            fb.delete();
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (model_ready) begin
      check("y", {16'h0, y0, y1, y2, y3}, {16'h0, exp_y});
      check("frame_valid", {31'h0, frame_valid}, {31'h0, exp_fv});
      check("sync_err", {31'h0, sync_err}, {31'h0, exp_se});
      check("par_err", {31'h0, par_err}, {31'h0, exp_pe});
      if (frame_valid === 1'b1) fv_seen++;
      if (sync_err === 1'b1) se_seen++;
      if (par_err === 1'b1) pe_seen++;
    end
  end

  task automatic beat(input bit s, input logic [WIDTH-1:0] v, input bit flip = 1'b0);
    @(negedge clk);
    valid = 1'b1;
    sync  = s;
    d     = v;
    p     = (^v) ^ flip;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      valid = 1'b0;
      sync  = 1'($urandom);
      d     = WIDTH'($urandom);
      p     = 1'($urandom);
    end
  endtask

  task automatic frame(input logic [15:0] w, input int gap = 0, input logic [3:0] flip = 4'b0);
    beat(1'b1, w[15:12], flip[0]);
    idle(gap);
    beat(1'b0, w[11:8], flip[1]);
    idle(gap);
    beat(1'b0, w[7:4], flip[2]);
    idle(gap);
    beat(1'b0, w[3:0], flip[3]);
  endtask

  task automatic pin(input string tag, input logic [15:0] y_exp, input int fv, input int se, input int pe);
    check({tag, "_y"}, {16'h0, y0, y1, y2, y3}, {16'h0, y_exp});
    check({tag, "_fv_count"}, fv, fv);
    check({tag, "_fv_count"}, fv_seen, fv);
    check({tag, "_se_count"}, se_seen, se);
    check({tag, "_pe_count"}, pe_seen, pe);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    valid = 1'b0;
    sync  = 1'b0;
    d     = '0;
    p     = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("reset_y", {16'h0, y0, y1, y2, y3}, 32'h0);
    check("reset_pulses", {29'h0, frame_valid, sync_err, par_err}, 32'h0);

    frame(16'h35AF);
    idle(2);
    pin("basic", 16'h35AF, 1, 0, 0);

    frame(16'h35AF, 2);
    idle(3);
    pin("stalls", 16'h35AF, 2, 0, 0);

    beat(1, 4'h1); beat(0, 4'h2);
    beat(1, 4'h7); beat(0, 4'h8); beat(0, 4'h9); beat(0, 4'h4);
    idle(2);
    pin("premature", 16'h7894, 3, 1, 0);

    frame(16'hCDE0);
    frame(16'h1234);
    idle(2);
    pin("back2back", 16'h1234, 5, 1, 0);

    beat(0, 4'h6);
    beat(0, 4'h5); beat(0, 4'h5); beat(0, 4'h5); beat(0, 4'h5);
    idle(2);
    pin("missing_sync", 16'h1234, 5, 2, 0);
    frame(16'h9876);
    idle(2);
    pin("recover", 16'h9876, 6, 2, 0);

    beat(1, 4'h1); beat(0, 4'h2); beat(0, 4'h3);
    beat(1, 4'hB); beat(0, 4'hC); beat(0, 4'hD); beat(0, 4'hE);
    idle(2);
    pin("sync_at_slot3", 16'hBCDE, 7, 3, 0);

    beat(1, 4'h1); beat(0, 4'h2);
    @(negedge clk);
    valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    beat(0, 4'h3); beat(0, 4'h4);
    idle(2);
    pin("reset_mid", 16'h0000, 7, 3, 0);

    frame(16'h1234);
    frame(16'h35AF, 0, 4'b0100);
    idle(2);
    pin("par_slot2", Y_A, FV_A, 3, PE_A);
    frame(16'h6789);
    idle(2);
    pin("par_clean", 16'h6789, FV_B, 3, PE_A);
    frame(16'hABCD, 0, 4'b1000);
    idle(2);
    pin("par_slot3", Y_C, FV_C, 3, PE_C);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
